// File: rtl/gpr_pkg.sv
// Shared GPR geometry defaults and the destination-index decoder used by the
// writeback arbiter for both write enables and the pending-load mask.
package gpr_pkg;

  localparam int GPR_NUM    = 32;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  // x0 is hardwired zero, so index 0 decodes to no enable at all.
  function automatic logic [GPR_NUM-1:0] gpr_decode(input logic [ADDR_WIDTH-1:0] idx);
    logic [GPR_NUM-1:0] oh;
    oh = '0;
    if (idx != '0) oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small circular queue of pending load writebacks (rd + data); exposes its
// occupancy and every slot's rd so the arbiter can build the pending mask.
module wb_fifo #(
  parameter int DEPTH      = 2,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [ADDR_WIDTH-1:0]        push_rd,
  input  logic [DATA_WIDTH-1:0]        push_data,
  input  logic                         pop,
  output logic [ADDR_WIDTH-1:0]        head_rd,
  output logic [DATA_WIDTH-1:0]        head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [ADDR_WIDTH-1:0]        entry_rd [DEPTH],
  output logic [DEPTH-1:0]             entry_valid
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0]      wptr;
  logic [PTR_W-1:0]      rptr;
  logic [ADDR_WIDTH-1:0] mem_rd   [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else begin
      if (push) begin
        entry_valid[wptr] <= 1'b1;
        wptr              <= next_ptr(wptr);
      end
      if (pop) begin
        entry_valid[rptr] <= 1'b0;
        rptr              <= next_ptr(rptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; validity is tracked separately above.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wptr]   <= push_rd;
      mem_data[wptr] <= push_data;
    end
  end

  assign head_rd   = mem_rd[rptr];
  assign head_data = mem_data[rptr];
  assign entry_rd  = mem_rd;

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Arbitrates the single GPR write port between the ALU and a queued LSU
// writeback path; loads are buffered so the ALU keeps its 1-cycle latency.
module gpr_wb_arbiter #(
  parameter int DATA_WIDTH = gpr_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = gpr_pkg::ADDR_WIDTH,
  parameter int LSU_DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_WIDTH-1:0]    alu_rd,
  input  logic [DATA_WIDTH-1:0]    alu_data,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [ADDR_WIDTH-1:0]    lsu_rd,
  input  logic [DATA_WIDTH-1:0]    lsu_data,
  output logic [2**ADDR_WIDTH-1:0] gpr_wen,
  output logic [DATA_WIDTH-1:0]    gpr_wdata,
  output logic [2**ADDR_WIDTH-1:0] pend_mask
);

  localparam int CNT_W = $clog2(LSU_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LSU_DEPTH);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Both readies depend only on registered queue state, never on valid.

  logic [CNT_W-1:0]      count;
  logic [ADDR_WIDTH-1:0] head_rd;
  logic [DATA_WIDTH-1:0] head_data;
  logic [ADDR_WIDTH-1:0] entry_rd [LSU_DEPTH];
  logic [LSU_DEPTH-1:0]  entry_valid;
  logic                  full;
  logic                  alu_hit;
  logic                  push;
  logic                  sel_alu;
  logic                  sel_lsu;
  logic [ADDR_WIDTH-1:0] issue_rd;
  logic [DATA_WIDTH-1:0] issue_data;

  wb_fifo #(
    .DEPTH      (LSU_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wb_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .push_rd     (lsu_rd),
    .push_data   (lsu_data),
    .pop         (sel_lsu),
    .head_rd     (head_rd),
    .head_data   (head_data),
    .count       (count),
    .entry_rd    (entry_rd),
    .entry_valid (entry_valid)
  );

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < LSU_DEPTH; i++) begin
      if (entry_valid[i]) pend_mask = pend_mask | gpr_pkg::gpr_decode(entry_rd[i]);
    end
  end

  // An ALU write to a register with a queued load must wait behind it.
  assign alu_hit   = pend_mask[alu_rd];
  assign full      = (count == FULL_CNT);
  assign lsu_ready = !full;
  assign alu_ready = !full && !alu_hit;
  assign push      = lsu_valid && lsu_ready;
  assign sel_alu   = alu_valid && alu_ready;
  assign sel_lsu   = full || (!sel_alu && (count != '0));

  assign issue_rd   = sel_lsu ? head_rd   : alu_rd;
  assign issue_data = sel_lsu ? head_data : alu_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpr_wen   <= '0;
      gpr_wdata <= '0;
    end else begin
      gpr_wen <= '0;
      if (sel_alu || sel_lsu) begin
        gpr_wen   <= gpr_pkg::gpr_decode(issue_rd);
        gpr_wdata <= issue_data;
      end
    end
  end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter: expected writes (cycle, enable, data)
// are queued at stimulus time and matched by a negedge monitor.
module tb_gpr_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_data = '0;
  logic [31:0] gpr_wen;
  logic [31:0] gpr_wdata;
  logic [31:0] pend_mask;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [79:0] exp_q[$];
  logic [79:0] exp_e;
  logic [79:0] got_e;
  logic [31:0] regs [32];

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  gpr_wb_arbiter #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (5),
    .LSU_DEPTH  (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .gpr_wen   (gpr_wen),
    .gpr_wdata (gpr_wdata),
    .pend_mask (pend_mask)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input int at, input logic [4:0] rd, input logic [31:0] d);
    logic [31:0] oh;
    oh = 32'd1 << rd;
    exp_q.push_back({16'(at), oh, d});
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (gpr_wen != '0) begin
      for (int i = 0; i < 32; i++) if (gpr_wen[i]) regs[i] = gpr_wdata;
      checks++;
      got_e = {16'(cyc), gpr_wen, gpr_wdata};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got cyc/wen/data %h expected no write", got_e);
      end else begin
        exp_e = exp_q.pop_front();
        if (got_e !== exp_e) begin
          errors++;
          $display("FAIL gpr_write: got cyc/wen/data %h expected %h", got_e, exp_e);
        end
      end
    end
  end

  initial begin
    int t;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_wen", gpr_wen, 32'h0);
    chk("reset_wdata", gpr_wdata, 32'h0);
    chk("reset_pend", pend_mask, 32'h0);
    chk("reset_lsu_ready", 32'(lsu_ready), 32'h1);
    chk("reset_alu_ready", 32'(alu_ready), 32'h1);
    rst_n = 1'b1;

    // ALU only
    step(); t = cyc;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hA5A5A5A5;
    expect_wr(t + 1, 5'd5, 32'hA5A5A5A5);
    settle();
    chk("alu_ready_idle", 32'(alu_ready), 32'h1);
    step(); alu_valid = 1'b0;
    step(); settle();
    chk("idle_wen", gpr_wen, 32'h0);
    chk("idle_wdata_hold", gpr_wdata, 32'hA5A5A5A5);

    // collision: ALU overtakes queued loads to other registers
    step(); t = cyc;
    lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h11;
    expect_wr(t + 2, 5'd4, 32'h22);
    expect_wr(t + 3, 5'd3, 32'h11);
    expect_wr(t + 4, 5'd6, 32'h33);
    settle();
    chk("col_lsu_ready0", 32'(lsu_ready), 32'h1);
    step();
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h22;
    lsu_rd = 5'd6; lsu_data = 32'h33;
    settle();
    chk("col_pend1", pend_mask, 32'h8);
    chk("col_alu_ready1", 32'(alu_ready), 32'h1);
    step(); alu_valid = 1'b0; lsu_valid = 1'b0; settle();
    chk("col_full_lsu_ready", 32'(lsu_ready), 32'h0);
    chk("col_full_alu_ready", 32'(alu_ready), 32'h0);
    chk("col_full_pend", pend_mask, 32'h48);
    step(); settle();
    chk("col_lsu_ready3", 32'(lsu_ready), 32'h1);
    chk("col_pend3", pend_mask, 32'h40);
    step(); step(); settle();
    chk("col_idle_wen", gpr_wen, 32'h0);
    chk("col_idle_wdata", gpr_wdata, 32'h33);

    // WAW on rd=7: ALU waits for the queued load
    step(); t = cyc;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h77;
    expect_wr(t + 2, 5'd7, 32'h77);
    expect_wr(t + 3, 5'd7, 32'hBEEF);
    step();
    lsu_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hBEEF;
    settle();
    chk("waw_alu_blocked", 32'(alu_ready), 32'h0);
    chk("waw_pend", pend_mask, 32'h80);
    step(); settle();
    chk("waw_alu_released", 32'(alu_ready), 32'h1);
    step(); alu_valid = 1'b0;
    step(); settle();
    chk("waw_final_gpr7", regs[7], 32'hBEEF);

    // rd=0 writes are consumed silently
    step();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1;
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h2;
    settle();
    chk("x0_alu_ready", 32'(alu_ready), 32'h1);
    chk("x0_lsu_ready", 32'(lsu_ready), 32'h1);
    step(); alu_valid = 1'b0; lsu_valid = 1'b0; settle();
    chk("x0_pend", pend_mask, 32'h0);
    step(); step(); settle();
    chk("x0_wen", gpr_wen, 32'h0);

    // reset with two loads queued
    step(); t = cyc;
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h101;
    expect_wr(t + 1, 5'd1, 32'h101);
    expect_wr(t + 2, 5'd2, 32'h202);
    step();
    lsu_rd = 5'd10; lsu_data = 32'hAA;
    alu_rd = 5'd2; alu_data = 32'h202;
    step(); lsu_valid = 1'b0; alu_valid = 1'b0; settle();
    chk("rst_pre_pend", pend_mask, 32'h600);
    chk("rst_pre_lsu_ready", 32'(lsu_ready), 32'h0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wen", gpr_wen, 32'h0);
    chk("rst_mid_pend", pend_mask, 32'h0);
    chk("rst_mid_lsu_ready", 32'(lsu_ready), 32'h1);
    chk("rst_mid_alu_ready", 32'(alu_ready), 32'h1);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (6) step();

    // queue still usable after reset
    t = cyc;
    lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_data = 32'hCC;
    expect_wr(t + 2, 5'd11, 32'hCC);
    step(); lsu_valid = 1'b0;

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    repeat (2) step();
    chk("drain_exp_q", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
